// File: rtl/eth_sched_pkg.sv
// Shared types for the Ethernet burst scheduler: FSM state encoding and default sizing.
// Optional header-beat feature is selected with SCHED_HDR_EN (see eth_burst_scheduler).
package eth_sched_pkg;

    localparam int NCH_DEF   = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        ARB   = 4'b0010,
        BURST = 4'b0100,
        GAP   = 4'b1000
    } state_t;

    // Channel index and counter types for the default sizing.
    typedef logic [$clog2(NCH_DEF)-1:0] ch_idx_t;
    typedef logic [CNT_W_DEF-1:0]       cnt_t;

endpackage

// File: rtl/eth_burst_scheduler_if.sv
// Handshake bundle between capture FIFOs / TX path and the burst scheduler.
// The hdr signal exists only when SCHED_HDR_EN is defined.
interface eth_burst_scheduler_if #(
    parameter int NCH = 4
);
    localparam int IW = $clog2(NCH);

    logic           arm;
    logic [NCH-1:0] empty;
    logic           tx_ready;
    logic [NCH-1:0] rd_en;
    logic [IW-1:0]  addr;
    logic           eth_en;
    logic           sof;
    logic           eof;
    logic           abort;
    logic           busy;
`ifdef SCHED_HDR_EN
    logic           hdr;
`endif

    modport master (
        input  arm, empty, tx_ready,
`ifdef SCHED_HDR_EN
        output hdr,
`endif
        output rd_en, addr, eth_en, sof, eof, abort, busy
    );

    modport slave (
        output arm, empty, tx_ready,
`ifdef SCHED_HDR_EN
        input  hdr,
`endif
        input  rd_en, addr, eth_en, sof, eof, abort, busy
    );

endinterface

// File: rtl/eth_burst_scheduler_rr_arbiter.sv
// Combinational rotate-priority picker: first requesting channel after ptr, wrapping modulo NCH.
module rr_arbiter #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [$clog2(NCH)-1:0] grant,
    output logic                   valid
);
    localparam int IW = $clog2(NCH);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate inward so the nearest requester after ptr wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = NCH; i >= 1; i--) begin
            cand = IW'((int'(ptr) + i) % NCH);
            if (req[cand]) begin
                grant = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_burst_scheduler.sv
// Round-robin burst scheduler draining NCH FWFT FIFOs into the shared Ethernet TX path.
// Define SCHED_HDR_EN to emit a header beat (hdr=1) ahead of each burst's payload.
module eth_burst_scheduler
    import eth_sched_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int BURST_LEN = 1024,
    parameter int GAP_LEN   = 8192,
    parameter int STALL_MAX = 64,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    eth_burst_scheduler_if.master bus
);
    localparam int IW = $clog2(NCH);

    localparam logic [CNT_W-1:0] BEAT_LAST  = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_LEN - 1);
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(STALL_MAX - 1);

`ifdef SCHED_HDR_EN
    localparam bit HDR_BEAT = 1'b1;
`else
    localparam bit HDR_BEAT = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [IW-1:0]    grant_addr, grant_addr_nxt;
    logic [IW-1:0]    last_grant, last_grant_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [IW-1:0]    arb_grant;
    logic             arb_valid;
    logic             granted_empty;
    logic             hdr_phase;

`ifdef SCHED_HDR_EN
    logic hdr_pend, hdr_pend_nxt;
    assign hdr_phase = hdr_pend;
`else
    assign hdr_phase = 1'b0;
`endif

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req   (~bus.empty),
        .ptr   (last_grant),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    assign granted_empty = bus.empty[grant_addr];
    assign bus.addr      = grant_addr;
    assign bus.busy      = (state != IDLE);

    always_comb begin
        // NOTE: every output and next-state value is defaulted first so no path infers a latch.
        state_nxt      = state;
        grant_addr_nxt = grant_addr;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        stall_cnt_nxt  = stall_cnt;
        gap_cnt_nxt    = gap_cnt;
        bus.rd_en      = '0;
        bus.eth_en     = 1'b0;
        bus.sof        = 1'b0;
        bus.eof        = 1'b0;
        bus.abort      = 1'b0;
`ifdef SCHED_HDR_EN
        bus.hdr        = 1'b0;
        hdr_pend_nxt   = hdr_pend;
`endif
        unique case (state)
            IDLE: begin
                if (bus.arm && !(&bus.empty)) state_nxt = ARB;
            end
            ARB: begin
                if (arb_valid) begin
                    grant_addr_nxt = arb_grant;
                    last_grant_nxt = arb_grant;
                    beat_cnt_nxt   = '0;
                    stall_cnt_nxt  = '0;
`ifdef SCHED_HDR_EN
                    hdr_pend_nxt   = 1'b1;
`endif
                    state_nxt      = BURST;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BURST: begin
                if (hdr_phase) begin
                    if (bus.tx_ready) begin
                        bus.eth_en   = 1'b1;
                        bus.sof      = 1'b1;
`ifdef SCHED_HDR_EN
                        bus.hdr      = 1'b1;
                        hdr_pend_nxt = 1'b0;
`endif
                    end
                end else if (bus.tx_ready && !granted_empty) begin
                    bus.rd_en[grant_addr] = 1'b1;
                    bus.eth_en            = 1'b1;
                    bus.sof               = (beat_cnt == '0) && !HDR_BEAT;
                    stall_cnt_nxt         = '0;
                    beat_cnt_nxt          = beat_cnt + 1'b1;
                    if (beat_cnt == BEAT_LAST) begin
                        bus.eof     = 1'b1;
                        gap_cnt_nxt = '0;
                        state_nxt   = GAP;
                    end
                end else if (bus.tx_ready) begin
                    // Only cycles where TX could have accepted a word count toward the timeout.
                    if (stall_cnt == STALL_LAST) begin
                        bus.abort   = 1'b1;
                        gap_cnt_nxt = '0;
                        state_nxt   = GAP;
                    end else begin
                        stall_cnt_nxt = stall_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = (&bus.empty) ? IDLE : ARB;
                end else begin
                    gap_cnt_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers take non-blocking assignments; the combinational block above uses blocking.
        if (rst) begin
            state      <= IDLE;
            grant_addr <= '0;
            last_grant <= IW'(NCH - 1);
            beat_cnt   <= '0;
            stall_cnt  <= '0;
            gap_cnt    <= '0;
`ifdef SCHED_HDR_EN
            hdr_pend   <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            grant_addr <= grant_addr_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            stall_cnt  <= stall_cnt_nxt;
            gap_cnt    <= gap_cnt_nxt;
`ifdef SCHED_HDR_EN
            hdr_pend   <= hdr_pend_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_eth_burst_scheduler.sv
// Self-checking bench for eth_burst_scheduler: directed scenarios plus a randomized soak
// compared every cycle against a phase-level reference model.
module tb_eth_burst_scheduler;

    localparam int NCH = 4;
    localparam int BL  = 4;
    localparam int GL  = 3;
    localparam int SM  = 5;
`ifdef SCHED_HDR_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    eth_burst_scheduler_if #(.NCH(NCH)) bus ();

    eth_burst_scheduler #(
        .NCH(NCH), .BURST_LEN(BL), .GAP_LEN(GL), .STALL_MAX(SM), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef enum int {P_IDLE, P_ARB, P_BURST, P_GAP} phase_e;

    phase_e m_ph;
    int     m_ch, m_last, m_beats, m_stalls, m_gap;
    bit     m_hdr;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int grants[$];
    int abort_cnt, eof_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ph     = P_IDLE;
        m_ch     = 0;
        m_last   = NCH - 1;
        m_beats  = 0;
        m_stalls = 0;
        m_gap    = 0;
        m_hdr    = 1'b0;
    endtask

    // One clock: drive inputs after the falling edge, compare, then advance the model.
    task automatic step(input bit a, input logic [NCH-1:0] e, input bit t);
        bit             payload, hdr_beat, stall, found;
        logic [NCH-1:0] exp_rd;
        logic [4:0]     exp_fl;
        payload  = 1'b0;
        hdr_beat = 1'b0;
        stall    = 1'b0;
        found    = 1'b0;
        @(negedge clk);
        cyc++;
        bus.arm      = a;
        bus.empty    = e;
        bus.tx_ready = t;
        #1;
        if (m_ph == P_BURST) begin
            if (HDR && m_hdr) hdr_beat = t;
            else begin
                payload = t && !e[m_ch];
                stall   = t && e[m_ch];
            end
        end
        exp_rd = '0;
        if (payload) exp_rd[m_ch] = 1'b1;
        exp_fl = {payload || hdr_beat,
                  hdr_beat || (payload && !HDR && m_beats == 0),
                  payload && m_beats == BL - 1,
                  stall && m_stalls == SM - 1,
                  m_ph != P_IDLE};
        check("rd_en", 32'(bus.rd_en), 32'(exp_rd));
        check("flags(eth_en,sof,eof,abort,busy)",
              32'({bus.eth_en, bus.sof, bus.eof, bus.abort, bus.busy}), 32'(exp_fl));
        check("addr", 32'(bus.addr), 32'(m_ch));
`ifdef SCHED_HDR_EN
        check("hdr", 32'(bus.hdr), 32'(hdr_beat));
`endif
        if (bus.sof)   grants.push_back(int'(bus.addr));
        if (bus.abort) abort_cnt++;
        if (bus.eof)   eof_cnt++;

        case (m_ph)
            P_IDLE: if (a && e != '1) m_ph = P_ARB;
            P_ARB: begin
                for (int k = 1; k <= NCH; k++) begin
                    if (!found && !e[(m_last + k) % NCH]) begin
                        found = 1'b1;
                        m_ch  = (m_last + k) % NCH;
                    end
                end
                if (found) begin
                    m_last   = m_ch;
                    m_beats  = 0;
                    m_stalls = 0;
                    m_hdr    = HDR;
                    m_ph     = P_BURST;
                end else begin
                    m_ph = P_IDLE;
                end
            end
            P_BURST: begin
                if (hdr_beat) m_hdr = 1'b0;
                else if (payload) begin
                    m_beats++;
                    m_stalls = 0;
                    if (m_beats == BL) begin
                        m_ph  = P_GAP;
                        m_gap = 0;
                    end
                end else if (stall) begin
                    if (m_stalls == SM - 1) begin
                        m_ph  = P_GAP;
                        m_gap = 0;
                    end else m_stalls++;
                end
            end
            P_GAP: begin
                if (m_gap == GL - 1) m_ph = (e != '1) ? P_ARB : P_IDLE;
                else m_gap++;
            end
            default: m_ph = P_IDLE;
        endcase
    endtask

    // Assert reset with the current inputs still applied; outputs must drop immediately.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        cyc++;
        check("rst_rd_en", 32'(bus.rd_en), 32'd0);
        check("rst_flags", 32'({bus.eth_en, bus.sof, bus.eof, bus.abort, bus.busy}), 32'd0);
        check("rst_addr", 32'(bus.addr), 32'd0);
        model_reset();
        bus.arm = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [NCH-1:0] e_hold;
        int             hold;
        int             abort_at;
        bit             reached;

        rst          = 1'b1;
        bus.arm      = 1'b0;
        bus.empty    = '1;
        bus.tx_ready = 1'b0;
        model_reset();
        #12;
        check("por_flags", 32'({bus.eth_en, bus.sof, bus.eof, bus.abort, bus.busy}), 32'd0);
        check("por_rd_en", 32'(bus.rd_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All channels full, TX always ready: strict rotation starting at ch0.
        grants.delete();
        repeat (44) step(1'b1, '0, 1'b1);
        check("rot_count_ge5", 32'(grants.size() >= 5), 32'd1);
        if (grants.size() >= 5) begin
            check("rot_g0", 32'(grants[0]), 32'd0);
            check("rot_g1", 32'(grants[1]), 32'd1);
            check("rot_g2", 32'(grants[2]), 32'd2);
            check("rot_g3", 32'(grants[3]), 32'd3);
            check("rot_g4", 32'(grants[4]), 32'd0);
        end

        // Reset in the middle of a burst.
        reached = 1'b0;
        for (int i = 0; i < 16 && !reached; i++) begin
            step(1'b1, '0, 1'b1);
            reached = (m_ph == P_BURST) && (m_beats == 1);
        end
        check("midburst_reached", 32'(reached), 32'd1);
        do_reset();

        // Only ch0 and ch2 hold data.
        grants.delete();
        repeat (36) step(1'b1, 4'b1010, 1'b1);
        check("sparse_count_ge4", 32'(grants.size() >= 4), 32'd1);
        if (grants.size() >= 4) begin
            check("sparse_g0", 32'(grants[0]), 32'd0);
            check("sparse_g1", 32'(grants[1]), 32'd2);
            check("sparse_g2", 32'(grants[2]), 32'd0);
            check("sparse_g3", 32'(grants[3]), 32'd2);
        end

        // TX ready toggling every cycle: slower bursts, never an abort.
        do_reset();
        abort_cnt = 0;
        eof_cnt   = 0;
        for (int i = 0; i < 30; i++) step(1'b1, '0, (i % 2) == 0);
        check("toggle_no_abort", 32'(abort_cnt), 32'd0);
        check("toggle_eof_seen", 32'(eof_cnt > 0), 32'd1);

        // Granted FIFO runs dry after two beats and stays dry.
        do_reset();
        reached = 1'b0;
        for (int i = 0; i < 12 && !reached; i++) begin
            step(1'b1, '0, 1'b1);
            reached = (m_ph == P_BURST) && (m_beats == 2);
        end
        check("stall_setup_reached", 32'(reached), 32'd1);
        abort_cnt = 0;
        eof_cnt   = 0;
        abort_at  = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, '1, 1'b1);
            if (bus.abort) abort_at = i;
        end
        check("abort_on_5th_stall", 32'(abort_at), 32'(SM));
        check("abort_once", 32'(abort_cnt), 32'd1);
        check("no_eof_on_abort", 32'(eof_cnt), 32'd0);
        check("idle_after_empty_gap", 32'(bus.busy), 32'd0);

        // Randomized soak: FIFO flags held for a few cycles at a time.
        do_reset();
        hold   = 0;
        e_hold = '0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                e_hold = NCH'($urandom);
                if ($urandom_range(0, 5) == 0) e_hold = '1;
                hold = $urandom_range(1, 10);
            end
            hold--;
            step($urandom_range(0, 7) != 0, e_hold, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
